// File: rtl/sys_arr_acc_post_if.sv
// rtl/sys_arr_acc_post_if.sv - vector stream interface for the accumulator post-processing stage
//
// Groups the accumulator-side input vector stream and the FIFO-side output
// vector stream.
//   in_vect_val/last/words : accumulator result vector, no back-pressure
//   out_vect_val/last/words: FIFO head vector towards the output writer
//   out_vect_rdy           : output writer ready
// slave  : the post-processing block
// master : the surroundings (accumulator + output writer)
interface sys_arr_acc_post_if #(
  parameter int VECT_SIZE    = 8,
  parameter int IN_WORD_WDT  = 32,
  parameter int OUT_WORD_WDT = 16
);
  logic                              in_vect_val;
  logic                              in_vect_last;
  logic [VECT_SIZE*IN_WORD_WDT-1:0]  in_vect_words;
  logic                              out_vect_val;
  logic                              out_vect_rdy;
  logic                              out_vect_last;
  logic [VECT_SIZE*OUT_WORD_WDT-1:0] out_vect_words;

  modport master (
    output in_vect_val, in_vect_last, in_vect_words, out_vect_rdy,
    input  out_vect_val, out_vect_last, out_vect_words
  );

  modport slave (
    input  in_vect_val, in_vect_last, in_vect_words, out_vect_rdy,
    output out_vect_val, out_vect_last, out_vect_words
  );
endinterface

// File: rtl/sys_arr_acc_post.sv
// rtl/sys_arr_acc_post.sv - requantize, saturate, ReLU and buffer accumulator result vectors
//
// Stage 1 registers the rounding right-shift of every word, stage 2 saturates
// and optionally clamps negatives while writing straight into a show-ahead
// FIFO, so a vector reaches the FIFO head two enabled cycles after input.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   clk_en            : global enable, all state holds when low
//   relu_en           : clamp negative results to zero
//   shift_amt         : rounding right-shift amount
//   bus               : input/output vector streams (slave side)
//   fifo_almost_full  : free entries <= AF_MARGIN
//   ovf_err           : sticky, a vector was dropped on a full FIFO
module sys_arr_acc_post #(
  parameter int VECT_SIZE    = 8,
  parameter int IN_WORD_WDT  = 32,
  parameter int OUT_WORD_WDT = 16,
  parameter int FIFO_DEPTH   = 8,
  parameter int AF_MARGIN    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clk_en,
  input  logic                relu_en,
  input  logic [4:0]          shift_amt,
  sys_arr_acc_post_if.slave   bus,
  output logic                fifo_almost_full,
  output logic                ovf_err
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int OW = VECT_SIZE * OUT_WORD_WDT;
  localparam int EW = OW + 1;
  localparam int XW = IN_WORD_WDT + 1;

  // Saturation bounds, sign-extended to the widened stage-1 word
  localparam logic signed [XW-1:0] SAT_MAX = {{(XW-OUT_WORD_WDT+1){1'b0}}, {(OUT_WORD_WDT-1){1'b1}}};
  localparam logic signed [XW-1:0] SAT_MIN = {{(XW-OUT_WORD_WDT+1){1'b1}}, {(OUT_WORD_WDT-1){1'b0}}};
  localparam logic [OUT_WORD_WDT-1:0] OUT_MAX = {1'b0, {(OUT_WORD_WDT-1){1'b1}}};
  localparam logic [OUT_WORD_WDT-1:0] OUT_MIN = {1'b1, {(OUT_WORD_WDT-1){1'b0}}};

  // ---------------- stage 1: rounding arithmetic shift ----------------
  logic signed [XW-1:0]    rnd;
  logic [IN_WORD_WDT-1:0]  x;
  logic signed [XW-1:0]    s1_nxt [VECT_SIZE];
  logic signed [XW-1:0]    s1_r   [VECT_SIZE];
  logic                    s1_val;
  logic                    s1_last;

  // Add half an LSB of the result before shifting (round half up); the add is
  // one bit wider than the input so large positive words cannot wrap.
  always_comb begin
    rnd = '0;
    x   = '0;
    if (shift_amt != 5'd0) rnd = XW'(1) << (shift_amt - 5'd1);
    for (int i = 0; i < VECT_SIZE; i++) begin
      x         = bus.in_vect_words[i*IN_WORD_WDT +: IN_WORD_WDT];
      s1_nxt[i] = ($signed({x[IN_WORD_WDT-1], x}) + rnd) >>> shift_amt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_val  <= 1'b0;
      s1_last <= 1'b0;
      for (int i = 0; i < VECT_SIZE; i++) s1_r[i] <= '0;
    end else if (clk_en) begin
      s1_val  <= bus.in_vect_val;
      s1_last <= bus.in_vect_last;
      for (int i = 0; i < VECT_SIZE; i++) s1_r[i] <= s1_nxt[i];
    end
  end

  // ---------------- stage 2: saturate + ReLU, written into FIFO -------
  logic [OW-1:0]           s2_words;
  logic [OUT_WORD_WDT-1:0] w;

  always_comb begin
    s2_words = '0;
    w        = '0;
    for (int i = 0; i < VECT_SIZE; i++) begin
      if (s1_r[i] > SAT_MAX)      w = OUT_MAX;
      else if (s1_r[i] < SAT_MIN) w = OUT_MIN;
      else                        w = s1_r[i][OUT_WORD_WDT-1:0];
      if (relu_en && w[OUT_WORD_WDT-1]) w = '0;
      s2_words[i*OUT_WORD_WDT +: OUT_WORD_WDT] = w;
    end
  end

  // ---------------- show-ahead FIFO ------------------------------------
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          push, pop, full, wr_en, drop;
  logic [EW-1:0] head;

  assign push  = s1_val & clk_en;
  assign pop   = bus.out_vect_val & bus.out_vect_rdy & clk_en;
  assign full  = (cnt == CW'(FIFO_DEPTH));
  // A pop in the same cycle frees the slot, so a full FIFO still accepts
  assign wr_en = push & (~full | pop);
  assign drop  = push & full & ~pop;

  always_comb begin
    cnt_nxt = cnt;
    if (wr_en && !pop)      cnt_nxt = cnt + CW'(1);
    else if (pop && !wr_en) cnt_nxt = cnt - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {s1_last, s2_words};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      cnt              <= '0;
      fifo_almost_full <= 1'b0;
      ovf_err          <= 1'b0;
    end else if (clk_en) begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (pop)   rd_ptr <= rd_ptr + PW'(1);
      cnt              <= cnt_nxt;
      fifo_almost_full <= (CW'(FIFO_DEPTH) - cnt_nxt) <= CW'(AF_MARGIN);
      if (drop) ovf_err <= 1'b1;
    end
  end

  // Head data is masked while empty so stale or unwritten entries never show
  assign head               = mem[rd_ptr];
  assign bus.out_vect_val   = (cnt != '0);
  assign bus.out_vect_last  = bus.out_vect_val & head[OW];
  assign bus.out_vect_words = bus.out_vect_val ? head[OW-1:0] : '0;

endmodule
